// File: rtl/shift_pkg.sv
// Shared types and constants for the right-shift execution unit.
package shift_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic SH_LOGICAL = 1'b0;
    localparam logic SH_ARITH   = 1'b1;

endpackage

// File: rtl/shift_right_step.sv
// Combinational right shift by k with a selectable fill bit; k >= WIDTH yields all fill.
module shift_right_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned K_W   = 6
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [K_W-1:0]   k,
    input  logic             fill,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        ones      = '1;
        // Bits vacated by the shift are the complement of the shifted all-ones mask.
        fill_mask = ~(ones >> k);
        data_out  = (data_in >> k) | ({WIDTH{fill}} & fill_mask);
    end

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle right-shift unit (SRL/SRA/SRLV/SRAV) for the EX stage.
// Define SHIFT_RIGHT_FAST_EN for a single-cycle barrel-shift build.
module shift_right_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = DEF_SHAMT_W,
    parameter int unsigned STEP    = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               start,
    input  logic               flush,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
);

    localparam int unsigned K_W = SHAMT_W + 1;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   data_q,   data_d;
    logic [SHAMT_W-1:0] cnt_q,    cnt_d;
    logic               arith_q,  arith_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [K_W-1:0]     step_k;
    logic               step_fill;
    logic [WIDTH-1:0]   step_out;

`ifdef SHIFT_RIGHT_FAST_EN
    always_comb begin
        step_k    = {1'b0, shamt};
        step_fill = (arith == SH_ARITH) & in_data[WIDTH-1];
    end
`else
    localparam logic [K_W-1:0] STEP_K = K_W'(STEP);

    logic [SHAMT_W-1:0] cnt_rem;

    // Clamp the step to the remaining count so cnt never underflows.
    always_comb begin
        if ({1'b0, cnt_q} < STEP_K) begin
            step_k = {1'b0, cnt_q};
        end else begin
            step_k = STEP_K;
        end
        step_fill = (arith_q == SH_ARITH) & data_q[WIDTH-1];
        cnt_rem   = cnt_q - step_k[SHAMT_W-1:0];
    end
`endif

    shift_right_step #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_step (
`ifdef SHIFT_RIGHT_FAST_EN
        .data_in  (in_data),
`else
        .data_in  (data_q),
`endif
        .k        (step_k),
        .fill     (step_fill),
        .data_out (step_out)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        arith_d  = arith_q;
        result_d = result_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (start) begin
                    data_d  = in_data;
                    cnt_d   = shamt;
                    arith_d = arith;
`ifdef SHIFT_RIGHT_FAST_EN
                    result_d = step_out;
                    state_d  = DONE;
`else
                    if (shamt == '0) begin
                        result_d = in_data;
                        state_d  = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
`ifdef SHIFT_RIGHT_FAST_EN
                state_d = IDLE;
`else
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    data_d = step_out;
                    cnt_d  = cnt_rem;
                    if (cnt_rem == '0) begin
                        result_d = step_out;
                        state_d  = DONE;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            cnt_q    <= '0;
            arith_q  <= SH_LOGICAL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            arith_q  <= arith_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed self-checking bench for shift_right_unit (STEP=1 and STEP=4 instances).
module tb_shift_right_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start;
    logic        flush;
    logic [31:0] in_data;
    logic [4:0]  shamt;
    logic        arith;

    logic [31:0] result1, result4;
    logic        busy1, busy4, done1, done4;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 Clk = ~Clk;

    shift_right_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
        .Clk (Clk), .Rst (Rst), .start (start), .flush (flush),
        .in_data (in_data), .shamt (shamt), .arith (arith),
        .result (result1), .busy (busy1), .done (done1)
    );

    shift_right_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
        .Clk (Clk), .Rst (Rst), .start (start), .flush (flush),
        .in_data (in_data), .shamt (shamt), .arith (arith),
        .result (result4), .busy (busy4), .done (done4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned exp_lat(input int unsigned sh, input int unsigned step);
`ifdef SHIFT_RIGHT_FAST_EN
        return 1;
`else
        return (sh + step - 1) / step + 1;
`endif
    endfunction

    // Called at a negedge; start is driven in the current cycle (cycle 0).
    // Returns at the negedge of the done cycle with start already low.
    task automatic run_op(input string tag, input bit use4, input logic [31:0] din,
                          input logic [4:0] sh, input logic ar, input logic [31:0] exp_res);
        int unsigned lat;
        int unsigned busy_cnt;
        int unsigned done_at;
        logic        b, d;
        logic [31:0] r;
        lat      = exp_lat(sh, use4 ? 4 : 1);
        busy_cnt = 0;
        done_at  = 0;
        r        = '0;
        start    = 1'b1;
        in_data  = din;
        shamt    = sh;
        arith    = ar;
        for (int n = 1; n <= 80; n++) begin
            @(negedge Clk);
            b = use4 ? busy4 : busy1;
            d = use4 ? done4 : done1;
            r = use4 ? result4 : result1;
            if (n == 1) begin
                start   = 1'b0;
                in_data = ~din;
                arith   = ~ar;
            end
            if (b) busy_cnt++;
            if (d) begin
                done_at = n;
                break;
            end
        end
        check_eq({tag, "_done_cycle"}, done_at, lat);
        check_eq({tag, "_result"}, r, exp_res);
        check_eq({tag, "_busy_cycles"}, busy_cnt, lat - 1);
    endtask

    initial begin
        int unsigned a_done;
        int unsigned b_done;
        logic [31:0] b_res;

        Rst = 1'b1; start = 1'b0; flush = 1'b0;
        in_data = '0; shamt = '0; arith = 1'b0;

        #3;
        check_eq("reset_result", result1, 32'h0);
        check_eq("reset_busy", {31'b0, busy1}, 32'h0);
        check_eq("reset_done", {31'b0, done1}, 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        run_op("sra4",  1'b0, 32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000);
        run_op("srl4",  1'b0, 32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000);
        run_op("sh0",   1'b0, 32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678);
        run_op("sra31", 1'b0, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);

        // Back-to-back: second start is issued during the first op's DONE cycle.
        run_op("b2b_a", 1'b0, 32'hA5A5_A5A5, 5'd0,  1'b1, 32'hA5A5_A5A5);
        run_op("b2b_b", 1'b0, 32'h0000_F000, 5'd12, 1'b0, 32'h0000_000F);

        // Flush during DONE drops a simultaneous start.
        run_op("fd", 1'b0, 32'h1357_9BDF, 5'd0, 1'b0, 32'h1357_9BDF);
        start = 1'b1; flush = 1'b1; in_data = 32'hDEAD_BEEF; shamt = 5'd0;
        @(negedge Clk);
        start = 1'b0; flush = 1'b0;
        check_eq("fd_done_low", {31'b0, done1}, 32'h0);
        check_eq("fd_busy_low", {31'b0, busy1}, 32'h0);
        check_eq("fd_result_kept", result1, 32'h1357_9BDF);
        @(negedge Clk);
        check_eq("fd_done_still_low", {31'b0, done1}, 32'h0);

`ifndef SHIFT_RIGHT_FAST_EN
        // Flush in SHIFT aborts op A; start during SHIFT of op B is ignored.
        a_done = 0; b_done = 0; b_res = '0;
        start = 1'b1; in_data = 32'h1111_0000; shamt = 5'd8; arith = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge Clk);
            if (n <= 4 && done1) a_done++;
            if (n > 4 && done1 && b_done == 0) begin
                b_done = n;
                b_res  = result1;
            end
            if (n == 1) start = 1'b0;
            if (n == 3) begin
                flush = 1'b1; start = 1'b1; shamt = 5'd0;
            end
            if (n == 4) begin
                check_eq("flush_idle", {31'b0, busy1}, 32'h0);
                flush = 1'b0; start = 1'b1;
                in_data = 32'h00F0_0000; shamt = 5'd3; arith = 1'b0;
            end
            if (n == 5) begin
                start = 1'b1; in_data = 32'hFFFF_FFFF; shamt = 5'd0; arith = 1'b1;
            end
            if (n == 6) start = 1'b0;
            if (n == 7) check_eq("flush_result_kept", result1, 32'h1357_9BDF);
        end
        check_eq("flush_no_done", a_done, 32'd0);
        check_eq("ignored_start_done_cycle", b_done, 32'd8);
        check_eq("ignored_start_result", b_res, 32'h001E_0000);
`endif

        // Asynchronous reset in the middle of a shift, away from any clock edge.
        run_op("pre_rst", 1'b0, 32'h0F00_0000, 5'd0, 1'b0, 32'h0F00_0000);
        start = 1'b1; in_data = 32'h8765_4321; shamt = 5'd10; arith = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        check_eq("rst_mid_result", result1, 32'h0);
        check_eq("rst_mid_busy", {31'b0, busy1}, 32'h0);
        check_eq("rst_mid_done", {31'b0, done1}, 32'h0);
        #1 Rst = 1'b0;
        @(negedge Clk);
        run_op("post_rst", 1'b0, 32'hF0F0_F0F0, 5'd4, 1'b1, 32'hFF0F_0F0F);

        run_op("s4_srl6", 1'b1, 32'hF000_0000, 5'd6, 1'b0, 32'h03C0_0000);
        run_op("s4_sra7", 1'b1, 32'h8000_0000, 5'd7, 1'b1, 32'hFF00_0000);

        @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
